// File: rtl/image_pkg.sv
// Shared definitions for the image streaming / enhancement / sink blocks.
// Default frame geometry, pixel width and the frame streamer state type.
package image_pkg;

   localparam int IMG_W     = 128;
   localparam int IMG_H     = 128;
   localparam int PIX_W     = 8;
   localparam int ADDR_W    = 14;
   localparam int FRAME_PIX = IMG_W * IMG_H;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } strm_state_t;

   // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry first-word-fall-through FIFO for returning pixel reads.
// When empty, the word being pushed is presented at the head in the same
// cycle, so a read result can be consumed without an extra register stage.
module pixel_skid_fifo #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        count,
   output logic [DATA_W-1:0] head,
   output logic              head_vld
);

   logic [DATA_W-1:0] slot_p1 [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic              pop_ok;
   logic              bypass;

   assign head_vld = (count != 2'd0) || push;
   assign head     = (count != 2'd0) ? slot_p1[rd_ptr] : push_data;
   assign pop_ok   = pop && head_vld;
   // An empty FIFO that is pushed and popped together passes the word straight through.
   assign bypass   = (count == 2'd0) && push && pop_ok;

   // Occupancy and pointer update; reset only touches control state.
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push && !bypass)
            wr_ptr <= ~wr_ptr;
         if (pop_ok && !bypass)
            rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop_ok);
      end
   end

   // Storage capture for words that are not consumed in their arrival cycle.
   always_ff @(posedge clk) begin
      if (push && !bypass)
         slot_p1[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/image_frame_streamer.sv
// Streams one stored greyscale frame from a synchronous-read pixel memory
// to the enhancement pipeline, with SOF/EOL markers, a done pulse and
// full support for downstream backpressure (at most two reads ahead).
module image_frame_streamer #(
   parameter int IMG_W  = image_pkg::IMG_W,
   parameter int IMG_H  = image_pkg::IMG_H,
   parameter int PIX_W  = image_pkg::PIX_W,
   parameter int ADDR_W = image_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [PIX_W-1:0]  mem_rd_data,
   output logic [PIX_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sof,
   output logic              out_eol,
   output logic              busy,
   output logic              frame_done
);

   import image_pkg::*;

   localparam int                NPIX      = IMG_W * IMG_H;
   localparam int                COL_W     = cnt_w(IMG_W);
   localparam int                ROW_W     = cnt_w(IMG_H);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_H - 1);

   strm_state_t       state_q;
   strm_state_t       state_d;
   logic              start_acc;
   logic [ADDR_W-1:0] rd_ptr_p0;
   logic              rd_en_p0;
   logic              vld_p1;
   logic [1:0]        fifo_count;
   logic [PIX_W-1:0]  fifo_head;
   logic              fifo_vld;
   logic [2:0]        occ;
   logic              pop;
   logic              last_xfer;
   logic [COL_W-1:0]  col_q;
   logic [ROW_W-1:0]  row_q;
   logic              done_q;

   // Pixels already committed to the buffer: stored words plus the read returning now.
   assign occ       = 3'(fifo_count) + 3'(vld_p1);
   assign pop       = fifo_vld && out_ready;
   assign last_xfer = pop && (row_q == LAST_ROW) && (col_q == LAST_COL);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next state and read issue; a read is issued only if its data is certain to fit.
   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      rd_en_p0  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = STREAM;
               start_acc = 1'b1;
            end
         end
         STREAM: begin
            rd_en_p0 = (occ < (3'd2 + 3'(pop)));
            if (rd_en_p0 && (rd_ptr_p0 == LAST_ADDR))
               state_d = DRAIN;
         end
         DRAIN: begin
            if (last_xfer)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage p0: linear read pointer, restarted for every accepted frame.
   always_ff @(posedge clk) begin
      if (rst || start_acc)
         rd_ptr_p0 <= '0;
      else if (rd_en_p0)
         rd_ptr_p0 <= rd_ptr_p0 + ADDR_W'(1);
   end

   // Stage p1: marks the cycle in which memory read data is valid.
   always_ff @(posedge clk) begin
      if (rst)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= rd_en_p0;
   end

   pixel_skid_fifo #(
      .DATA_W    (PIX_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (vld_p1),
      .push_data (mem_rd_data),
      .pop       (pop),
      .count     (fifo_count),
      .head      (fifo_head),
      .head_vld  (fifo_vld)
   );

   // Output-side row/column position, advanced only by completed transfers.
   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         col_q <= '0;
         row_q <= '0;
      end else if (pop) begin
         if (col_q == LAST_COL) begin
            col_q <= '0;
            if (row_q != LAST_ROW)
               row_q <= row_q + ROW_W'(1);
         end else begin
            col_q <= col_q + COL_W'(1);
         end
      end
   end

   // Frame completion pulse, one cycle after the final pixel is accepted.
   always_ff @(posedge clk) begin
      if (rst)
         done_q <= 1'b0;
      else
         done_q <= last_xfer;
   end

   assign mem_rd_en  = rd_en_p0;
   assign mem_addr   = rd_ptr_p0;
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;
   assign out_valid  = fifo_vld;
   assign out_data   = fifo_vld ? fifo_head : '0;
   assign out_sof    = fifo_vld && (row_q == '0) && (col_q == '0);
   assign out_eol    = fifo_vld && (col_q == LAST_COL);

endmodule

// File: tb/tb_image_frame_streamer.sv
// Bench for image_frame_streamer: full-speed, random-backpressure,
// back-to-back, mid-frame start/reset and a small 4x3 configuration.
module tb_image_frame_streamer;

   localparam int W   = 128;
   localparam int H   = 128;
   localparam int N   = W * H;
   localparam int AW  = 14;
   localparam int SW  = 4;
   localparam int SH  = 3;
   localparam int SN  = SW * SH;
   localparam int SAW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          rst, start, out_ready;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rd_data;
   logic [7:0]    out_data;
   logic          out_valid, out_sof, out_eol, busy, frame_done;

   logic           s_start, s_ready, s_rd_en;
   logic [SAW-1:0] s_addr;
   logic [7:0]     s_rd_data, s_data;
   logic           s_valid, s_sof, s_eol, s_busy, s_done;

   image_frame_streamer #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sof(out_sof), .out_eol(out_eol), .busy(busy), .frame_done(frame_done)
   );

   image_frame_streamer #(.IMG_W(SW), .IMG_H(SH), .PIX_W(8), .ADDR_W(SAW)) dut_s (
      .clk(clk), .rst(rst), .start(s_start),
      .mem_rd_en(s_rd_en), .mem_addr(s_addr), .mem_rd_data(s_rd_data),
      .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready),
      .out_sof(s_sof), .out_eol(s_eol), .busy(s_busy), .frame_done(s_done)
   );

   function automatic logic [7:0] s_pix(input int k);
      return 8'((k * 5 + 1) % 256);
   endfunction

   // Frame memories with one-cycle synchronous read.
   logic [7:0] mem [N];
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   always @(posedge clk) if (s_rd_en) s_rd_data <= s_pix(int'(s_addr));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference stream monitor: the k-th accepted pixel of a frame must be
   // pixel k (k mod 256), SOF only at k=0, EOL at the end of every row.
   bit         mon_en = 1'b0;
   int         xfers, issued, pix_err, stab_err, out_err, addr_err;
   int         done_cnt, done_err, first_x_cyc, last_x_cyc, done_cyc, mk;
   logic       prev_stall, prev_sof, prev_eol;
   logic [7:0] prev_data;

   task automatic mon_clear();
      xfers = 0; issued = 0; pix_err = 0; stab_err = 0; out_err = 0; addr_err = 0;
      done_cnt = 0; done_err = 0; first_x_cyc = -1; last_x_cyc = -1; done_cyc = -1;
      prev_stall = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_stall && !(out_valid === 1'b1 && out_data === prev_data &&
                             out_sof === prev_sof && out_eol === prev_eol))
            stab_err++;
         if (mem_rd_en === 1'b1) begin
            if (mem_addr !== AW'(issued % N)) addr_err++;
            issued++;
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            mk = xfers % N;
            if (out_data !== 8'(mk % 256) || out_sof !== (mk == 0) || out_eol !== ((mk % W) == W - 1))
               pix_err++;
            if (xfers == 0) first_x_cyc = cyc;
            last_x_cyc = cyc;
            xfers++;
         end
         if (issued - xfers > 2) out_err++;
         if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy !== 1'b0) done_err++;
         end
         prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
         prev_data  = out_data;
         prev_sof   = out_sof;
         prev_eol   = out_eol;
      end
   end

   bit rdy_rand = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, "_rd_en"},   mem_rd_en,  0);
      chk({p, "_addr"},    mem_addr,   0);
      chk({p, "_data"},    out_data,   0);
      chk({p, "_valid"},   out_valid,  0);
      chk({p, "_sof"},     out_sof,    0);
      chk({p, "_eol"},     out_eol,    0);
      chk({p, "_busy"},    busy,       0);
      chk({p, "_done"},    frame_done, 0);
   endtask

   int t0, timed_out, any_done, sk, s_done_n, s_done_c, s_last_c;
   bit pulsed;

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      s_start = 1'b0; s_ready = 1'b1;
      mon_clear();
      for (int i = 0; i < N; i++) mem[i] = 8'(i % 256);

      // Reset state.
      repeat (3) tick();
      chk_reset_vals("rst0");
      chk("rst0_s_busy", s_busy, 0);
      chk("rst0_s_valid", s_valid, 0);
      rst = 1'b0;
      tick(); tick();

      // Frame A: full speed, stray start pulse at transfer 1000.
      mon_clear(); mon_en = 1'b1;
      start = 1'b1; tick(); start = 1'b0; t0 = cyc;
      chk("A_busy", busy, 1);
      chk("A_rd_en", mem_rd_en, 1);
      chk("A_addr0", mem_addr, 0);
      chk("A_valid_early", out_valid, 0);
      tick();
      chk("A_valid_first", out_valid, 1);
      chk("A_sof_first", out_sof, 1);
      chk("A_data_first", out_data, 0);
      timed_out = 1; pulsed = 1'b0;
      for (int i = 0; i < N + 100; i++) begin
         tick();
         start = 1'b0;
         if (!pulsed && xfers >= 1000) begin start = 1'b1; pulsed = 1'b1; end
         if (frame_done === 1'b1) begin timed_out = 0; break; end
      end
      start = 1'b0;
      chk("A_timeout", timed_out, 0);
      chk("A_done_cyc", cyc, t0 + N + 1);
      chk("A_busy_at_done", busy, 0);

      // Frame B: start in the frame_done cycle, random backpressure.
      start = 1'b1; rdy_rand = 1'b1;
      tick(); start = 1'b0;
      chk("B_busy", busy, 1);
      chk("B_rd_en", mem_rd_en, 1);
      chk("B_addr0", mem_addr, 0);
      tick();
      chk("B_valid_first", out_valid, 1);
      chk("B_sof_first", out_sof, 1);
      chk("B_data_first", out_data, 0);
      chk("A_xfers", xfers, N);
      chk("A_pix_err", pix_err, 0);
      chk("A_first_x", first_x_cyc, t0 + 1);
      chk("A_last_x", last_x_cyc, t0 + N);
      chk("A_done_cnt", done_cnt, 1);
      timed_out = 1;
      for (int i = 0; i < 80000; i++) begin
         tick();
         if (frame_done === 1'b1) begin timed_out = 0; break; end
      end
      chk("B_timeout", timed_out, 0);
      chk("B_busy_at_done", busy, 0);
      rdy_rand = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("B_xfers", xfers, 2 * N);
      chk("B_pix_err", pix_err, 0);
      chk("B_stable", stab_err, 0);
      chk("B_outstanding", out_err, 0);
      chk("B_addr_order", addr_err, 0);
      chk("B_done_cnt", done_cnt, 2);
      chk("B_done_after_last", done_cyc, last_x_cyc + 1);
      chk("B_done_busy", done_err, 0);

      // Frame C: reset at transfer 5000 while stalled.
      mon_clear();
      start = 1'b1; tick(); start = 1'b0;
      timed_out = 1;
      for (int i = 0; i < 6000; i++) begin
         tick();
         if (xfers >= 5000) begin timed_out = 0; break; end
      end
      chk("C_reach", timed_out, 0);
      chk("C_busy_pre", busy, 1);
      out_ready = 1'b0; rst = 1'b1; mon_en = 1'b0;
      tick();
      chk_reset_vals("C_rst");
      rst = 1'b0;
      any_done = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (frame_done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) any_done++;
      end
      chk("C_quiet_after_rst", any_done, 0);

      // Frame D: restart after reset, full speed.
      mon_clear(); mon_en = 1'b1; out_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0; t0 = cyc;
      chk("D_busy", busy, 1);
      tick();
      chk("D_valid_first", out_valid, 1);
      chk("D_sof_first", out_sof, 1);
      chk("D_data_first", out_data, 0);
      timed_out = 1;
      for (int i = 0; i < N + 100; i++) begin
         tick();
         if (frame_done === 1'b1) begin timed_out = 0; break; end
      end
      chk("D_timeout", timed_out, 0);
      chk("D_done_cyc", cyc, t0 + N + 1);
      tick(); tick();
      chk("D_xfers", xfers, N);
      chk("D_pix_err", pix_err, 0);
      chk("D_done_cnt", done_cnt, 1);
      chk("D_stable", stab_err, 0);
      chk("D_outstanding", out_err, 0);
      chk("D_addr_order", addr_err, 0);

      // Small 4x3 configuration.
      mon_en = 1'b0;
      sk = 0; s_done_n = 0; s_done_c = -1; s_last_c = -1;
      s_start = 1'b1; tick(); s_start = 1'b0;
      chk("S_busy", s_busy, 1);
      for (int i = 0; i < 30; i++) begin
         tick();
         if (s_done === 1'b1) begin s_done_n++; s_done_c = cyc; end
         if (s_valid === 1'b1 && s_ready === 1'b1) begin
            chk($sformatf("S_data%0d", sk), s_data, s_pix(sk));
            chk($sformatf("S_eol%0d", sk), s_eol, ((sk % SW) == SW - 1));
            chk($sformatf("S_sof%0d", sk), s_sof, (sk == 0));
            s_last_c = cyc;
            sk++;
         end
      end
      chk("S_count", sk, SN);
      chk("S_done_n", s_done_n, 1);
      chk("S_done_after_last", s_done_c, s_last_c + 1);
      chk("S_idle", s_busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
